game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 147 ++++++++++++++
 tb/tb_game_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller.
// Sequences TITLE -> PLAY -> DIED/WIN screens -> GAMEOVER/VICTORY, tracks the
// current level and remaining lives, and issues a one-cycle active-low restart
// pulse to the gameplay FSMs on every entry into PLAY.
// Optional feature: define GAME_SEQ_LVL_WRAP_EN to make completion of the last
// level wrap back to level 0 (lives kept) instead of entering VICTORY.
module game_sequencer #(
  parameter int SCREEN_SEC  = 3,  // died/win screen duration in one_sec ticks (1..15)
  parameter int START_LIVES = 3,  // lives loaded at game start (1..7)
  parameter int NUM_LEVELS  = 4   // number of levels (1..8)
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       start_key,
  input  logic       bumpy_died,
  input  logic       level_comp,
  output logic       title_screen,
  output logic       died_screen,
  output logic       win_screen,
  output logic       gameover_screen,
  output logic       victory_screen,
  output logic       play_en,
  output logic       reset_fsm_N,
  output logic [2:0] lvl,
  output logic [2:0] lives
);

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAY,
    S_DIED,
    S_WIN,
    S_GAMEOVER,
    S_VICTORY
  } state_t;

  localparam logic [3:0] TIMER_LAST = 4'(SCREEN_SEC - 1);
  localparam logic [2:0] LVL_LAST   = 3'(NUM_LEVELS - 1);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_timer, w_timer_nxt;
  logic [2:0] r_lvl, w_lvl_nxt;
  logic [2:0] r_lives, w_lives_nxt;
  logic       r_rst_fsm_n, w_rst_fsm_n_nxt;
  logic       w_expire;

  // The screen ends on the tick that arrives while the timer holds its last value.
  assign w_expire = one_sec && (r_timer == TIMER_LAST);

  // State, timer, level, lives and restart pulse registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_TITLE;
      r_timer     <= 4'd0;
      r_lvl       <= 3'd0;
      r_lives     <= 3'd0;
      r_rst_fsm_n <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_lvl       <= w_lvl_nxt;
      r_lives     <= w_lives_nxt;
      r_rst_fsm_n <= w_rst_fsm_n_nxt;
    end
  end

  // Next-state, timer, level and lives decode; inputs not consumed by a state are ignored.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_lvl_nxt   = r_lvl;
    w_lives_nxt = r_lives;

    case (r_state)
      S_TITLE: begin
        if (start_key) begin
          w_state_nxt = S_PLAY;
          w_lives_nxt = LIVES_INIT;
          w_lvl_nxt   = 3'd0;
        end
      end
      S_PLAY: begin
        // Level completion takes priority over a simultaneous death.
        if (level_comp) begin
          w_state_nxt = S_WIN;
          w_timer_nxt = 4'd0;
        end else if (bumpy_died) begin
          if (r_lives > 3'd1) begin
            w_state_nxt = S_DIED;
            w_lives_nxt = r_lives - 3'd1;
            w_timer_nxt = 4'd0;
          end else begin
            w_state_nxt = S_GAMEOVER;
            w_lives_nxt = 3'd0;
          end
        end
      end
      S_DIED: begin
        if (one_sec) w_timer_nxt = r_timer + 4'd1;
        if (w_expire) w_state_nxt = S_PLAY;
      end
      S_WIN: begin
        if (one_sec) w_timer_nxt = r_timer + 4'd1;
        if (w_expire) begin
          if (r_lvl < LVL_LAST) begin
            w_state_nxt = S_PLAY;
            w_lvl_nxt   = r_lvl + 3'd1;
          end else begin
`ifdef GAME_SEQ_LVL_WRAP_EN
            w_state_nxt = S_PLAY;
            w_lvl_nxt   = 3'd0;
`else
            w_state_nxt = S_VICTORY;
`endif
          end
        end
      end
      S_GAMEOVER, S_VICTORY: begin
        // Level and lives stay visible until the next game starts from TITLE.
        if (start_key) w_state_nxt = S_TITLE;
      end
      default: w_state_nxt = S_TITLE;
    endcase

    // Restart pulse is low for the single cycle after any entry into PLAY.
    w_rst_fsm_n_nxt = !((w_state_nxt == S_PLAY) && (r_state != S_PLAY));
  end

  assign title_screen    = (r_state == S_TITLE);
  assign died_screen     = (r_state == S_DIED);
  assign win_screen      = (r_state == S_WIN);
  assign gameover_screen = (r_state == S_GAMEOVER);
`ifdef GAME_SEQ_LVL_WRAP_EN
  assign victory_screen  = 1'b0;
`else
  assign victory_screen  = (r_state == S_VICTORY);
`endif
  assign play_en         = (r_state == S_PLAY);
  assign reset_fsm_N     = r_rst_fsm_n;
  assign lvl             = r_lvl;
  assign lives           = r_lives;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: self-checking bench for game_sequencer.
// Directed vector table, hand-written multi-cycle sequences (level run to the
// end, reset mid-screen) and a randomized run against a behavioural model.
module tb_game_sequencer;

  localparam int SCREEN_SEC  = 3;
  localparam int START_LIVES = 3;
  localparam int NUM_LEVELS  = 4;

  // Bench-side screen codes.
  localparam int SC_TITLE = 0;
  localparam int SC_PLAY  = 1;
  localparam int SC_DIED  = 2;
  localparam int SC_WIN   = 3;
  localparam int SC_GO    = 4;
  localparam int SC_VIC   = 5;

  logic       clk = 1'b0;
  logic       resetN;
  logic       one_sec, start_key, bumpy_died, level_comp;
  logic       title_screen, died_screen, win_screen, gameover_screen, victory_screen;
  logic       play_en, reset_fsm_N;
  logic [2:0] lvl, lives;

  int checks   = 0;
  int failures = 0;

  game_sequencer #(
    .SCREEN_SEC (SCREEN_SEC),
    .START_LIVES(START_LIVES),
    .NUM_LEVELS (NUM_LEVELS)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .one_sec        (one_sec),
    .start_key      (start_key),
    .bumpy_died     (bumpy_died),
    .level_comp     (level_comp),
    .title_screen   (title_screen),
    .died_screen    (died_screen),
    .win_screen     (win_screen),
    .gameover_screen(gameover_screen),
    .victory_screen (victory_screen),
    .play_en        (play_en),
    .reset_fsm_N    (reset_fsm_N),
    .lvl            (lvl),
    .lives          (lives)
  );

  always #5 clk = ~clk;

  // Observed outputs: {title,died,win,gameover,victory,play_en,reset_fsm_N,lvl,lives}
  logic [12:0] w_dut;
  assign w_dut = {title_screen, died_screen, win_screen, gameover_screen, victory_screen,
                  play_en, reset_fsm_N, lvl, lives};

  function automatic logic [12:0] pack_exp(input int scr, input logic rf,
                                           input logic [2:0] l, input logic [2:0] lv);
    return {scr == SC_TITLE, scr == SC_DIED, scr == SC_WIN, scr == SC_GO, scr == SC_VIC,
            scr == SC_PLAY, rf, l, lv};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got scr/pe/rf=%b lvl=%0d lives=%0d, expected scr/pe/rf=%b lvl=%0d lives=%0d",
               name, act[12:6], act[5:3], act[2:0], exp[12:6], exp[5:3], exp[2:0]);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_scr, m_lvl, m_lives, m_ticks_left;
  logic m_rf;

  task automatic m_reset();
    m_scr        = SC_TITLE;
    m_lvl        = 0;
    m_lives      = 0;
    m_ticks_left = 0;
    m_rf         = 1'b0;
  endtask

  task automatic m_step(input logic sk, input logic bd, input logic lc, input logic os);
    int prev;
    prev = m_scr;
    case (m_scr)
      SC_TITLE: if (sk) begin m_scr = SC_PLAY; m_lives = START_LIVES; m_lvl = 0; end
      SC_PLAY: begin
        if (lc) begin
          m_scr = SC_WIN; m_ticks_left = SCREEN_SEC;
        end else if (bd) begin
          if (m_lives > 1) begin m_lives--; m_scr = SC_DIED; m_ticks_left = SCREEN_SEC; end
          else begin m_lives = 0; m_scr = SC_GO; end
        end
      end
      SC_DIED: if (os) begin
        m_ticks_left--;
        if (m_ticks_left == 0) m_scr = SC_PLAY;
      end
      SC_WIN: if (os) begin
        m_ticks_left--;
        if (m_ticks_left == 0) begin
          if (m_lvl < NUM_LEVELS - 1) begin m_lvl++; m_scr = SC_PLAY; end
          else begin
`ifdef GAME_SEQ_LVL_WRAP_EN
            m_lvl = 0; m_scr = SC_PLAY;
`else
            m_scr = SC_VIC;
`endif
          end
        end
      end
      default: if (sk) m_scr = SC_TITLE;
    endcase
    m_rf = !(m_scr == SC_PLAY && prev != SC_PLAY);
  endtask

  function automatic logic [12:0] m_exp();
    return pack_exp(m_scr, m_rf, 3'(m_lvl), 3'(m_lives));
  endfunction

  // ---------------- stimulus helpers ----------------
  // Inputs are held across one rising edge, then outputs are read 1 time unit later.
  task automatic step(input logic sk, input logic bd, input logic lc, input logic os);
    start_key  = sk;
    bumpy_died = bd;
    level_comp = lc;
    one_sec    = os;
    @(posedge clk);
    #1;
    m_step(sk, bd, lc, os);
    start_key  = 1'b0;
    bumpy_died = 1'b0;
    level_comp = 1'b0;
    one_sec    = 1'b0;
  endtask

  task automatic do_reset();
    start_key  = 1'b0;
    bumpy_died = 1'b0;
    level_comp = 1'b0;
    one_sec    = 1'b0;
    resetN     = 1'b0;
    m_reset();
    #2;
    check("reset_state", w_dut, pack_exp(SC_TITLE, 1'b0, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       sk, bd, lc, os;
    int         scr;
    logic       rf;
    logic [2:0] l, lv;
    string      name;
  } vec_t;

  function automatic vec_t mk(input logic sk, input logic bd, input logic lc, input logic os,
                              input int scr, input logic rf, input logic [2:0] l,
                              input logic [2:0] lv, input string name);
    vec_t v;
    v.sk = sk; v.bd = bd; v.lc = lc; v.os = os;
    v.scr = scr; v.rf = rf; v.l = l; v.lv = lv; v.name = name;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //              sk   bd   lc   os    screen    rf  lvl lives
    tbl.push_back(mk(0, 0, 0, 0, SC_TITLE, 1, 0, 0, "idle_after_reset"));
    tbl.push_back(mk(1, 0, 0, 0, SC_PLAY,  0, 0, 3, "start_game"));
    tbl.push_back(mk(0, 0, 0, 0, SC_PLAY,  1, 0, 3, "restart_pulse_ends"));
    tbl.push_back(mk(0, 0, 0, 1, SC_PLAY,  1, 0, 3, "tick_in_play_ignored"));
    tbl.push_back(mk(0, 1, 0, 0, SC_DIED,  1, 0, 2, "first_death"));
    tbl.push_back(mk(0, 0, 0, 1, SC_DIED,  1, 0, 2, "died_tick1"));
    tbl.push_back(mk(0, 0, 0, 0, SC_DIED,  1, 0, 2, "died_no_tick"));
    tbl.push_back(mk(0, 0, 0, 1, SC_DIED,  1, 0, 2, "died_tick2"));
    tbl.push_back(mk(1, 1, 1, 0, SC_DIED,  1, 0, 2, "died_ignores_keys"));
    tbl.push_back(mk(0, 0, 0, 1, SC_PLAY,  0, 0, 2, "died_expire_to_play"));
    tbl.push_back(mk(0, 0, 0, 0, SC_PLAY,  1, 0, 2, "replay_pulse_ends"));
    tbl.push_back(mk(0, 1, 1, 1, SC_WIN,   1, 0, 2, "comp_beats_death"));
    tbl.push_back(mk(0, 0, 0, 1, SC_WIN,   1, 0, 2, "win_tick1"));
    tbl.push_back(mk(0, 0, 0, 1, SC_WIN,   1, 0, 2, "win_tick2"));
    tbl.push_back(mk(0, 1, 0, 0, SC_WIN,   1, 0, 2, "win_ignores_death"));
    tbl.push_back(mk(0, 0, 0, 1, SC_PLAY,  0, 1, 2, "win_expire_next_lvl"));
    tbl.push_back(mk(0, 1, 0, 0, SC_DIED,  1, 1, 1, "second_death"));
    tbl.push_back(mk(0, 0, 0, 1, SC_DIED,  1, 1, 1, "died2_tick1"));
    tbl.push_back(mk(0, 0, 0, 1, SC_DIED,  1, 1, 1, "died2_tick2"));
    tbl.push_back(mk(0, 0, 0, 1, SC_PLAY,  0, 1, 1, "died2_expire"));
    tbl.push_back(mk(0, 1, 0, 0, SC_GO,    1, 1, 0, "last_death_gameover"));
    tbl.push_back(mk(0, 1, 0, 0, SC_GO,    1, 1, 0, "gameover_ignores_death"));
    tbl.push_back(mk(0, 0, 1, 1, SC_GO,    1, 1, 0, "gameover_ignores_comp"));
    tbl.push_back(mk(1, 0, 0, 0, SC_TITLE, 1, 1, 0, "gameover_to_title_hold"));
    tbl.push_back(mk(0, 1, 1, 1, SC_TITLE, 1, 1, 0, "title_ignores_others"));
    tbl.push_back(mk(1, 0, 0, 0, SC_PLAY,  0, 0, 3, "new_game_reloads"));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].sk, tbl[i].bd, tbl[i].lc, tbl[i].os);
      check(tbl[i].name, w_dut, pack_exp(tbl[i].scr, tbl[i].rf, tbl[i].l, tbl[i].lv));
    end

    // ---- hand sequence: play through every level ----
    step(0, 0, 0, 0);
    for (int k = 0; k < NUM_LEVELS; k++) begin
      step(0, 0, 1, 0);
      check("lvl_win_entry", w_dut, pack_exp(SC_WIN, 1'b1, 3'(k), 3'd3));
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("lvl_win_hold", w_dut, pack_exp(SC_WIN, 1'b1, 3'(k), 3'd3));
      step(0, 0, 0, 1);
      if (k < NUM_LEVELS - 1)
        check("lvl_advance", w_dut, pack_exp(SC_PLAY, 1'b0, 3'(k + 1), 3'd3));
      else begin
`ifdef GAME_SEQ_LVL_WRAP_EN
        check("lvl_wrap", w_dut, pack_exp(SC_PLAY, 1'b0, 3'd0, 3'd3));
`else
        check("victory", w_dut, pack_exp(SC_VIC, 1'b0 | 1'b1, 3'(NUM_LEVELS - 1), 3'd3));
`endif
      end
      step(0, 0, 0, 0);
    end
`ifdef GAME_SEQ_LVL_WRAP_EN
    check("wrap_play_hold", w_dut, pack_exp(SC_PLAY, 1'b1, 3'd0, 3'd3));
`else
    step(0, 1, 1, 1);
    check("victory_ignores", w_dut, pack_exp(SC_VIC, 1'b1, 3'(NUM_LEVELS - 1), 3'd3));
    step(1, 0, 0, 0);
    check("victory_to_title", w_dut, pack_exp(SC_TITLE, 1'b1, 3'(NUM_LEVELS - 1), 3'd3));
`endif

    // ---- hand sequence: reset in the middle of a WIN screen ----
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("win_timer1", w_dut, pack_exp(SC_WIN, 1'b1, 3'd0, 3'd3));
    #2;
    resetN = 1'b0;
    m_reset();
    #1;
    check("async_reset_mid_win", w_dut, pack_exp(SC_TITLE, 1'b0, 3'd0, 3'd0));
    @(posedge clk);
    #1;
    resetN = 1'b1;
    step(0, 0, 0, 0);
    check("post_reset_rf_high", w_dut, pack_exp(SC_TITLE, 1'b1, 3'd0, 3'd0));
    step(1, 0, 0, 0);
    check("restart_play", w_dut, pack_exp(SC_PLAY, 1'b0, 3'd0, 3'd3));
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("fresh_win_two_ticks", w_dut, pack_exp(SC_WIN, 1'b1, 3'd0, 3'd3));
    step(0, 0, 0, 1);
    check("fresh_win_expire", w_dut, pack_exp(SC_PLAY, 1'b0, 3'd1, 3'd3));

    // ---- randomized run against the model ----
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
      check("random", w_dut, m_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
